// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, sequencer state encoding and default width
// for the ALU command sequencer and its reference model.
package alu_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 8-function ALU; used as the expected
// result source for the optional self-check.
module alu_ref_model
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_mode)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_NOT:  o_result = WIDTH'(i_a == '0);
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_LT:   o_result = WIDTH'(i_a < i_b);
            OP_EQ:   o_result = WIDTH'(i_a == i_b);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the combinational 8-function ALU: accept command, drive ALU,
// wait SETTLE_CYCLES, capture and return result. Optional self-check: ALU_CMD_SEQUENCER_SELFCHECK_EN.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [2:0]       alu_mode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_op,
    output logic             rsp_zero,
    output logic             busy,
    output logic [7:0]       op_count,
    output logic             mismatch
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_ready;
    logic [2:0]       r_alu_mode;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [WIDTH-1:0] r_last_result;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic [2:0]       r_rsp_op;
    logic             r_rsp_zero;
    logic [7:0]       r_op_count;

    logic w_accept;
    logic w_capture;
    logic w_handshake;

    // cmd_ready is a registered copy of (state == IDLE), so it gates accept directly
    assign w_accept    = cmd_valid && r_cmd_ready;
    assign w_capture   = (r_state == SETTLE) && (r_cnt == '0);
    assign w_handshake = r_rsp_valid && rsp_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_next = SETTLE;
            SETTLE:  if (r_cnt == '0) w_state_next = RESP;
            RESP:    if (w_handshake) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b1;
            r_alu_mode    <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_last_result <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_op      <= '0;
            r_rsp_zero    <= 1'b0;
            r_op_count    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= (w_state_next == IDLE);

            if (w_accept) begin
                r_alu_mode <= cmd_op;
                r_alu_a    <= cmd_chain ? r_last_result : cmd_a;
                r_alu_b    <= cmd_b;
                r_cnt      <= CNT_INIT;
            end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_capture) begin
                r_rsp_result  <= alu_result;
                r_last_result <= alu_result;
                r_rsp_op      <= r_alu_mode;
                r_rsp_zero    <= (alu_result == '0);
                r_rsp_valid   <= 1'b1;
            end

            if (w_handshake) begin
                r_rsp_valid <= 1'b0;
                r_op_count  <= r_op_count + 8'd1;
            end
        end
    end

`ifdef ALU_CMD_SEQUENCER_SELFCHECK_EN
    logic [WIDTH-1:0] w_expected;
    logic             r_mismatch;

    alu_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .i_mode   (r_alu_mode),
        .i_a      (r_alu_a),
        .i_b      (r_alu_b),
        .o_result (w_expected)
    );

    // Sticky: only reset clears it, so a single bad sample stays visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else if (w_capture) begin
            r_mismatch <= r_mismatch | (alu_result != w_expected);
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

    assign cmd_ready  = r_cmd_ready;
    assign alu_mode   = r_alu_mode;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_op     = r_rsp_op;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = (r_state != IDLE);
    assign op_count   = r_op_count;

endmodule
